// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux: arbitration mode
// encodings and the select-index width helper.
package rr_arb_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_grant.sv
// Combinational arbiter: picks one requester either round-robin from ptr or
// by fixed priority (lowest index wins), returning one-hot grant and index.
module rr_grant #(
  parameter int N_CH = 4,
  parameter int SW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  input  logic            mode,
  output logic [N_CH-1:0] grant,
  output logic [SW-1:0]   grant_idx,
  output logic            grant_any
);

  // Scan N_CH candidates in priority order; the first requester found wins.
  always_comb begin
    logic [SW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = mode ? SW'(k) : SW'((int'(ptr) + k) % N_CH);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready mux with a single registered output stage; the
// source channel is chosen round-robin or by fixed priority.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int  N_CH = 4,
  parameter int  DW   = 8,
  parameter int  MODE = MODE_RR,
  localparam int SW   = sel_width(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_valid,
  output logic [N_CH-1:0]    in_ready,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [DW-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]   out_sel_q, out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   ptr_q, ptr_d;

  logic [N_CH-1:0] grant;
  logic [SW-1:0]   grant_idx;
  logic            grant_any;
  logic            load;
  logic            xfer;

  rr_grant #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_grant (
    .req       (in_valid),
    .ptr       (ptr_q),
    .mode      (MODE == MODE_FIXED),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The output register can accept a word when empty or being drained.
  assign load     = !out_valid_q || out_ready;
  assign xfer     = load && grant_any;
  assign in_ready = grant & {N_CH{load}};

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q && !out_ready;
    if (xfer) begin
      out_data_d  = in_data[int'(grant_idx)*DW +: DW];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = SW'((int'(grant_idx) + 1) % N_CH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a round-robin instance and a fixed-priority
// instance share the same stimulus; outputs checked against hand-computed values.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rr_in_ready;
  logic [7:0]  rr_out_data;
  logic [1:0]  rr_out_sel;
  logic        rr_out_valid;

  logic [3:0]  fx_in_ready;
  logic [7:0]  fx_out_data;
  logic [1:0]  fx_out_sel;
  logic        fx_out_valid;

  int tests;
  int fails;

  rr_arb_mux #(.N_CH(4), .DW(8), .MODE(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rr_in_ready),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_valid (rr_out_valid),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.N_CH(4), .DW(8), .MODE(1)) dut_fx (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (fx_in_ready),
    .out_data  (fx_out_data),
    .out_sel   (fx_out_sel),
    .out_valid (fx_out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;

    // Reset state
    #12;
    check_output("rst_out_valid", 32'(rr_out_valid), 32'h0);
    check_output("rst_out_data",  32'(rr_out_data),  32'h0);
    check_output("rst_out_sel",   32'(rr_out_sel),   32'h0);
    check_output("rst_in_ready",  32'(rr_in_ready),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All channels requesting: 0,1,2,3,0 back to back
    in_valid = 4'b1111;
    #1;
    check_output("rr_first_ready", 32'(rr_in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output("rr_seq_sel",   32'(rr_out_sel),   32'(k % 4));
      check_output("rr_seq_data",  32'(rr_out_data),  32'(8'h10 + k % 4));
      check_output("rr_seq_valid", 32'(rr_out_valid), 32'h1);
    end

    // Only channel 2 valid (ptr=1): A5 then arbitration resumes at 3
    in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
    in_valid = 4'b0100;
    #1;
    check_output("ch2_ready", 32'(rr_in_ready), 32'h4);
    tick();
    check_output("ch2_data", 32'(rr_out_data), 32'hA5);
    check_output("ch2_sel",  32'(rr_out_sel),  32'h2);
    in_valid = 4'b1111;
    #1;
    check_output("after_ch2_ready", 32'(rr_in_ready), 32'h8);
    tick();
    check_output("after_ch2_sel", 32'(rr_out_sel), 32'h3);

    // Drive ptr to 3, then only channel 0 requests: wrap-around
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid = 4'b0100;
    tick();
    check_output("pre_wrap_sel", 32'(rr_out_sel), 32'h2);
    in_valid = 4'b0001;
    #1;
    check_output("wrap_ready", 32'(rr_in_ready), 32'h1);
    tick();
    check_output("wrap_sel",  32'(rr_out_sel),  32'h0);
    check_output("wrap_data", 32'(rr_out_data), 32'h10);
    in_valid = 4'b1111;
    #1;
    check_output("wrap_ptr_ready", 32'(rr_in_ready), 32'h2);

    // Backpressure for 5 cycles: output and ptr hold, no accepts
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data = {8'h23 + 8'(k), 8'h22, 8'h21, 8'h20};
      #1;
      check_output("stall_ready", 32'(rr_in_ready), 32'h0);
      tick();
      check_output("stall_data",  32'(rr_out_data),  32'h10);
      check_output("stall_sel",   32'(rr_out_sel),   32'h0);
      check_output("stall_valid", 32'(rr_out_valid), 32'h1);
    end
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1;
    check_output("unstall_ready", 32'(rr_in_ready), 32'h2);
    tick();
    check_output("unstall_sel",  32'(rr_out_sel),  32'h1);
    check_output("unstall_data", 32'(rr_out_data), 32'h11);

    // Drain with no requests: valid drops, ptr stays at 2
    in_valid = 4'b0000;
    tick();
    check_output("drain_valid", 32'(rr_out_valid), 32'h0);
    tick();
    in_valid = 4'b1111;
    #1;
    check_output("idle_ptr_ready", 32'(rr_in_ready), 32'h4);

    // Fixed priority with in_valid=1010: channel 1 every cycle
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_output("fx_ready", 32'(fx_in_ready), 32'h2);
      tick();
      check_output("fx_sel",   32'(fx_out_sel),   32'h1);
      check_output("fx_data",  32'(fx_out_data),  32'h11);
      check_output("fx_valid", 32'(fx_out_valid), 32'h1);
    end

    // Asynchronous reset mid-cycle while holding a word
    in_valid = 4'b1111;
    tick();
    check_output("pre_rst_valid", 32'(rr_out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(rr_out_valid), 32'h0);
    check_output("async_rst_data",  32'(rr_out_data),  32'h0);
    check_output("async_rst_sel",   32'(rr_out_sel),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("post_rst_ready", 32'(rr_in_ready), 32'h1);
    tick();
    check_output("post_rst_sel",   32'(rr_out_sel),   32'h0);
    check_output("post_rst_data",  32'(rr_out_data),  32'h10);
    check_output("post_rst_valid", 32'(rr_out_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter DW, default 8: data width per channel.
REQ-003 SHALL have parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (channel 0 highest).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_data, input, N_CH*DW bits: channel i occupies bits [i*DW +: DW].
REQ-007 SHALL have port in_valid, input, N_CH bits: per-channel request.
REQ-008 SHALL have port in_ready, output, N_CH bits: per-channel accept.
REQ-009 SHALL have port out_data, output, DW bits: registered selected data.
REQ-010 SHALL have port out_sel, output, SW = max(1, clog2(N_CH)) bits: registered index of the source channel.
REQ-011 SHALL have port out_valid, output, 1 bit: output register holds data.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-013 SHALL define load = (!out_valid || out_ready); a transfer on channel i occurs when in_valid[i] && in_ready[i] at a rising clk edge.
REQ-014 SHALL assert at most one in_ready bit per cycle: in_ready[g] = load && in_valid[g], where g is the granted channel; all other bits are 0.
REQ-015 SHALL, for MODE=0, grant the first requesting channel found searching upward from pointer ptr and wrapping from N_CH-1 to 0.
REQ-016 SHALL, for MODE=1, grant the lowest-index requesting channel; ptr is unused.
REQ-017 SHALL, on a transfer from channel g, set out_data = in_data[g], out_sel = g and out_valid = 1 at that edge (latency 1 cycle), and set ptr = (g+1) mod N_CH.
REQ-018 SHALL clear out_valid at an edge where out_valid && out_ready and no transfer occurs.
REQ-019 SHALL keep out_valid = 1 and load new data at an edge with a simultaneous drain and transfer, sustaining 1 word per cycle.
REQ-020 SHALL, while out_valid && !out_ready, hold out_data, out_sel and ptr stable, and hold all in_ready bits at 0.
REQ-021 SHALL leave ptr unchanged when no channel requests.
REQ-022 SHALL, in MODE=0, serve any continuously requesting channel within N_CH transfers.
REQ-023 SHALL have in_ready depend combinationally on in_valid, out_valid and out_ready only; out_* SHALL be register outputs.

Reset
REQ-024 SHALL, while rst_n = 0, immediately force out_valid = 0, out_data = 0, out_sel = 0 and ptr = 0, regardless of clk.
REQ-025 SHALL discard any word held in the output register when reset is asserted mid-operation; it is never presented after reset.
REQ-026 SHALL, on the first edge after rst_n rises, arbitrate from ptr = 0.

Structure
REQ-027 SHALL place the MODE encodings (MODE_RR = 0, MODE_FIXED = 1) and the SW width function in the shared mux package/header.
REQ-028 SHALL implement arbitration in one combinational sub-module rr_grant (inputs req, ptr, mode; output one-hot grant plus index); datapath and registers stay in rr_arb_mux.

Verification
REQ-029 SHALL cover: N_CH=4, DW=8, MODE=0, all in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid constantly 1.
REQ-030 SHALL cover: only channel 2 valid with data 8'hA5 -> out_data=8'hA5, out_sel=2 one cycle later; next arbitration starts at channel 3.
REQ-031 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_sel stable and in_ready=0 throughout; on out_ready=1 the next word loads the same edge.
REQ-032 SHALL cover: MODE=1 with in_valid=4'b1010 -> channel 1 granted every cycle while channel 1 stays valid.
REQ-033 SHALL cover: ptr=3 and in_valid=4'b0001 -> channel 0 granted (wrap-around), ptr becomes 1.
REQ-034 SHALL cover: rst_n pulled low between clock edges while out_valid=1 -> out_valid=0 immediately; after release the first grant goes to channel 0 when all channels request.
